// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the multi-word nibble-serial add/subtract sequencer.
//   state_t : sequencer states (IDLE, RUN, DONE)
//   NIB_W   : width of one adder slice in bits
package multiword_add_seq_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiword_add_seq_adder.sv
// CarryRippleAdder: purely combinational ripple-carry adder slice.
//   a, b : addends
//   cin  : carry-in
//   s    : sum
//   cout : carry-out of the top bit
module CarryRippleAdder
  import multiword_add_seq_pkg::*;
#(
  parameter int unsigned WIDTH = NIB_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  always_comb begin
    logic [WIDTH:0] c;
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[WIDTH];
  end

endmodule

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: wide add/subtract computed one nibble per cycle through a
// single 4-bit CarryRippleAdder, with the carry registered between nibbles.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request (accepted in IDLE or DONE)
//   sub, cin   : operation select and carry/borrow-in, captured with start
//   op_a, op_b : operands (W = 4*NIBBLES bits), captured with start
//   busy       : high while in RUN
//   done       : one-cycle completion pulse
//   sum, cout, ovf : result, final carry (inverted borrow in sub), signed overflow
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       sub,
  input  logic                       cin,
  input  logic [NIBBLES*NIB_W-1:0]   op_a,
  input  logic [NIBBLES*NIB_W-1:0]   op_b,
  output logic                       busy,
  output logic                       done,
  output logic [NIBBLES*NIB_W-1:0]   sum,
  output logic                       cout,
  output logic                       ovf
);

  localparam int unsigned W  = NIBBLES * NIB_W;
  localparam int unsigned IW = $clog2(NIBBLES);

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    res_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;

  logic [NIB_W-1:0] a_nib;
  logic [NIB_W-1:0] b_nib;
  logic [NIB_W-1:0] s_nib;
  logic             c_nib;
  logic [W-1:0]     res_next;
  logic             last;

  assign a_nib = a_q[idx_q*NIB_W +: NIB_W];
  assign b_nib = b_q[idx_q*NIB_W +: NIB_W];
  assign last  = (idx_q == IW'(NIBBLES - 1));

  CarryRippleAdder #(
    .WIDTH (NIB_W)
  ) u_adder (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .s    (s_nib),
    .cout (c_nib)
  );

  // Working result with the current nibble merged in, so the final nibble is
  // visible to the sum/ovf capture in the same cycle it is produced.
  always_comb begin
    res_next = res_q;
    res_next[idx_q*NIB_W +: NIB_W] = s_nib;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction as A + ~B + ~cin; the inversion is folded into capture.
            a_q     <= op_a;
            b_q     <= sub ? ~op_b : op_b;
            carry_q <= cin ^ sub;
            res_q   <= '0;
            idx_q   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          res_q   <= res_next;
          carry_q <= c_nib;
          idx_q   <= idx_q + 1'b1;
          if (last) begin
            sum   <= res_next;
            cout  <= c_nib;
            ovf   <= (a_q[W-1] == b_q[W-1]) && (res_next[W-1] != a_q[W-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
